// File: rtl/pulse_timer_bank.sv
// Bank of independent programmable pulse timers, each periodic or one-shot,
// with a shared pause and a strobed per-channel configuration port.
module pulse_timer_bank #(
   parameter int CHANNELS       = 4,
   parameter int WIDTH          = 25,
   parameter int DEFAULT_PERIOD = 17500000
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [CHANNELS-1:0]   Enable,
   input  logic                  Pause,
   input  logic                  LoadValid,
   input  logic [3:0]            LoadChannel,
   input  logic [WIDTH-1:0]      LoadPeriod,
   input  logic                  LoadOneShot,
   output logic [CHANNELS-1:0]   PulseOutput,
   output logic [CHANNELS-1:0]   Done,
   output logic                  AnyPulse,
   output logic [2*CHANNELS-1:0] ChannelState
);

   // Handshake: LoadValid is a single-cycle strobe with no ready; a write is
   // taken on every edge where LoadValid is high and LoadChannel names a
   // channel that exists, otherwise it is dropped without effect.

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } chan_state_t;

   logic [CHANNELS-1:0] pulse_next;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic [WIDTH-1:0] period_q;
      logic [WIDTH-1:0] counter_q;
      logic             oneshot_q;
      logic             done_q;
      logic             pulse_q;
      chan_state_t      state_q;

      logic [WIDTH-1:0] counter_d;
      logic             done_d;
      logic             pulse_d;
      chan_state_t      state_d;
      logic             load_hit;

      assign load_hit = LoadValid && (LoadChannel == 4'(c));

      // Priority: disable > load > pause > count. Comparing against Period-1
      // before incrementing keeps the counter strictly below Period.
      always_comb begin
         counter_d = counter_q;
         done_d    = done_q;
         pulse_d   = 1'b0;
         if (!Enable[c] || load_hit) begin
            counter_d = '0;
            done_d    = 1'b0;
         end else if (Pause) begin
            counter_d = counter_q;
            done_d    = done_q;
         end else if (period_q == '0) begin
            counter_d = '0;
            done_d    = 1'b0;
         end else if (done_q) begin
            counter_d = '0;
         end else if (counter_q == period_q - WIDTH'(1)) begin
            counter_d = '0;
            pulse_d   = 1'b1;
            done_d    = oneshot_q;
         end else begin
            counter_d = counter_q + WIDTH'(1);
         end

         if (!Enable[c])
            state_d = ST_IDLE;
         else if (done_d)
            state_d = ST_EXPIRED;
         else
            state_d = ST_RUN;
      end

      always_ff @(posedge Clock or negedge Reset) begin
         if (!Reset) begin
            period_q  <= WIDTH'(DEFAULT_PERIOD);
            oneshot_q <= 1'b0;
            counter_q <= '0;
            done_q    <= 1'b0;
            pulse_q   <= 1'b0;
            state_q   <= ST_IDLE;
         end else begin
            if (load_hit) begin
               period_q  <= LoadPeriod;
               oneshot_q <= LoadOneShot;
            end
            counter_q <= counter_d;
            done_q    <= done_d;
            pulse_q   <= pulse_d;
            state_q   <= state_d;
         end
      end

      assign pulse_next[c]          = pulse_d;
      assign PulseOutput[c]         = pulse_q;
      assign Done[c]                = done_q;
      assign ChannelState[2*c +: 2] = state_q;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset)
         AnyPulse <= 1'b0;
      else
         AnyPulse <= |pulse_next;
   end

endmodule

// File: doc/pulse_timer_bank.md
PULSE_TIMER_BANK -- requirements
Module: pulse_timer_bank

Interface
REQ-001 Parameter CHANNELS, default 4, sets the number of independent timer channels (1..16).
REQ-002 Parameter WIDTH, default 25, sets the counter and period width in bits.
REQ-003 Parameter DEFAULT_PERIOD, default 17500000, sets the period every channel holds after reset (must fit in WIDTH).
REQ-004 Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Enable  input  CHANNELS  per-channel run enable; low clears that channel.
REQ-007 Pause  input  1  global hold; counters freeze, no clearing.
REQ-008 LoadValid  input  1  one-cycle strobe to write a channel configuration.
REQ-009 LoadChannel  input  4  target channel index for LoadValid.
REQ-010 LoadPeriod  input  WIDTH  new period in clock cycles.
REQ-011 LoadOneShot  input  1  new mode: 1 = one-shot, 0 = periodic.
REQ-012 PulseOutput  output  CHANNELS  per-channel one-cycle pulse, registered.
REQ-013 Done  output  CHANNELS  per-channel one-shot-expired flag, registered.
REQ-014 AnyPulse  output  1  registered OR of all PulseOutput bits, same cycle as them.

Function
REQ-015 Each channel SHALL hold Period (WIDTH bits), OneShot (1 bit), Counter (WIDTH bits) and Done (1 bit).
REQ-016 Channel states: IDLE (Enable low), RUN (Enable high, Done low), EXPIRED (Enable high, Done high, one-shot only).
REQ-017 IDLE: Counter <= 0, PulseOutput <= 0, Done <= 0 every cycle Enable is low.
REQ-018 RUN, Pause low, Period >= 1: Counter == Period-1 -> Counter <= 0, PulseOutput <= 1; otherwise Counter <= Counter+1, PulseOutput <= 0.
REQ-019 First pulse SHALL be registered exactly Period rising edges after the first edge at which Enable is sampled high; periodic pulses then repeat every Period cycles.
REQ-020 Period == 1: PulseOutput held high every enabled, unpaused cycle.
REQ-021 Period == 0: channel never pulses; Counter held 0, Done held 0.
REQ-022 One-shot: on the edge issuing the pulse, Done <= 1 and channel enters EXPIRED; EXPIRED holds Counter 0, PulseOutput 0 until Enable low or a load to that channel.
REQ-023 Pause high: Counter and Done hold; PulseOutput <= 0; Pause does not delay time beyond the paused cycles.
REQ-024 LoadValid with LoadChannel < CHANNELS: Period <= LoadPeriod, OneShot <= LoadOneShot, Counter <= 0, Done <= 0, PulseOutput <= 0 for that channel on that edge; other channels unaffected.
REQ-025 LoadValid with LoadChannel >= CHANNELS SHALL be ignored with no state change.
REQ-026 Priority per channel: Enable low > load > Pause > count; a load on a disabled channel still updates Period and OneShot.
REQ-027 Counter arithmetic SHALL never wrap: compare-before-increment guarantees Counter < Period.
REQ-028 AnyPulse SHALL equal the OR of the PulseOutput values registered on the same edge.

Reset
REQ-029 Reset low SHALL immediately force Counter 0, PulseOutput 0, Done 0, AnyPulse 0, Period DEFAULT_PERIOD, OneShot 0 on all channels, independent of Clock.
REQ-030 Reset assertion mid-count SHALL discard progress; after release counting restarts per REQ-019.
REQ-031 Reset release SHALL be taken synchronously by the integrator; the block adds no internal synchroniser.

Verification
REQ-032 CHANNELS=4, WIDTH=8; load ch0 Period 5 periodic, Enable[0] high -> PulseOutput[0] high on edges 5, 10, 15 after enable, low elsewhere; AnyPulse matches.
REQ-033 Load ch1 Period 3 one-shot, Enable[1] high -> single pulse at edge 3, Done[1] high from edge 3, no further pulses for 20 cycles; drop Enable[1] one cycle, raise -> pulse again at edge 3.
REQ-034 ch0 Period 5 running, Pause high 4 cycles after edge 2 -> first pulse at edge 9, not 5.
REQ-035 Load ch2 Period 0 and ch3 Period 1, both enabled -> PulseOutput[2] never high, PulseOutput[3] high every cycle; LoadChannel 7 leaves all state unchanged.
REQ-036 Reset low asynchronously at counter 3 of Period 5 -> outputs 0 before next edge, Period reverts to DEFAULT_PERIOD; load and enable after release behave per REQ-032.
